// File: rtl/ddr3_bank_cmd_sequencer.sv
// rtl/ddr3_bank_cmd_sequencer.sv - DDR3 multi-bank command sequencer with open-row tracking and periodic refresh
// Optional closed-page policy selected by defining DDR_CLOSED_PAGE_EN.
module ddr3_bank_cmd_sequencer #(
  parameter int NUM_BANKS = 8,
  parameter int BA_W      = 3,
  parameter int ROW_W     = 15,
  parameter int COL_W     = 10,
  parameter int T_RCD     = 5,
  parameter int T_RP      = 5,
  parameter int T_RFC     = 10,
  parameter int T_REFI    = 780
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 INIT_DONE,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic                 REQ_WRITE,
  input  logic                 REQ_AP,
  input  logic                 REQ_BL8,
  input  logic [BA_W-1:0]      REQ_BA,
  input  logic [ROW_W-1:0]     REQ_ROW,
  input  logic [COL_W-1:0]     REQ_COL,
  output logic                 CS_n,
  output logic                 RAS_n,
  output logic                 CAS_n,
  output logic                 WE_n,
  output logic [ROW_W-1:0]     Addr_out,
  output logic [BA_W-1:0]      BA_out,
  output logic                 CMD_RW,
  output logic [NUM_BANKS-1:0] BANK_OPEN,
  output logic                 REF_BUSY
);

`ifdef DDR_CLOSED_PAGE_EN
  localparam bit CLOSED_PAGE = 1'b1;
`else
  localparam bit CLOSED_PAGE = 1'b0;
`endif

  localparam int TMAX  = (T_RFC > T_RCD) ? ((T_RFC > T_RP) ? T_RFC : T_RP)
                                         : ((T_RCD > T_RP) ? T_RCD : T_RP);
  localparam int TMR_W = $clog2(TMAX);
  localparam int REF_W = $clog2(T_REFI);

  typedef enum logic [2:0] {
    S_INIT, S_READY, S_WAIT_RCD, S_WAIT_RP_ACT, S_WAIT_RP_REF, S_WAIT_RP_IDLE, S_WAIT_RFC
  } state_t;

  typedef enum logic [2:0] {
    C_DESEL, C_NOP, C_ACT, C_PRE, C_PREA, C_RW, C_REF
  } cmd_t;

  state_t                 state, state_d;
  cmd_t                   cmd;
  logic [TMR_W-1:0]       tmr, tmr_d;
  logic [REF_W-1:0]       ref_cnt;
  logic                   ref_due, ref_due_d, ref_wrap, ref_clear;
  logic [NUM_BANKS-1:0]   bank_open;
  logic [ROW_W-1:0]       open_row [NUM_BANKS];
  logic                   lat_write, lat_ap, lat_bl8;
  logic [BA_W-1:0]        lat_ba;
  logic [ROW_W-1:0]       lat_row;
  logic [COL_W-1:0]       lat_col;
  logic                   accept, hit, ap_eff;
  logic                   cmd_write, cmd_ap, cmd_bl8;
  logic [BA_W-1:0]        cmd_ba;
  logic [ROW_W-1:0]       cmd_row;
  logic [COL_W-1:0]       cmd_col;
  logic [ROW_W-1:0]       rw_addr, prea_addr, addr_d;
  logic [BA_W-1:0]        ba_d;
  logic                   cs_d, ras_d, cas_d, we_d;

  assign accept    = REQ_VALID && REQ_READY;
  assign hit       = bank_open[REQ_BA] && (open_row[REQ_BA] == REQ_ROW);
  // Fields come straight from the port on the accepting cycle, else from the latch.
  assign cmd_write = accept ? REQ_WRITE : lat_write;
  assign cmd_ap    = accept ? REQ_AP    : lat_ap;
  assign cmd_bl8   = accept ? REQ_BL8   : lat_bl8;
  assign cmd_ba    = accept ? REQ_BA    : lat_ba;
  assign cmd_row   = accept ? REQ_ROW   : lat_row;
  assign cmd_col   = accept ? REQ_COL   : lat_col;
  assign ap_eff    = CLOSED_PAGE || cmd_ap;
  assign ref_wrap  = (state != S_INIT) && (ref_cnt == REF_W'(T_REFI - 1));
  assign ref_due_d = (ref_due && !ref_clear) || ref_wrap;
  assign BANK_OPEN = bank_open;
  assign REF_BUSY  = ref_due;

  // Next-state and command decision; the chosen command reaches the pins next cycle.
  always_comb begin
    state_d   = state;
    tmr_d     = (tmr != '0) ? tmr - TMR_W'(1) : tmr;
    cmd       = C_NOP;
    ref_clear = 1'b0;
    case (state)
      S_INIT: begin
        cmd = C_DESEL;
        if (INIT_DONE) state_d = S_READY;
      end
      S_READY: begin
        if (ref_due) begin
          if ((|bank_open) && !CLOSED_PAGE) begin
            cmd = C_PREA; tmr_d = TMR_W'(T_RP - 1); state_d = S_WAIT_RP_REF;
          end else begin
            cmd = C_REF; tmr_d = TMR_W'(T_RFC - 1); state_d = S_WAIT_RFC;
          end
        end else if (accept) begin
          if (hit) begin
            cmd = C_RW;
            if (ap_eff) begin tmr_d = TMR_W'(T_RP - 1); state_d = S_WAIT_RP_IDLE; end
          end else if (bank_open[REQ_BA]) begin
            cmd = C_PRE; tmr_d = TMR_W'(T_RP - 1); state_d = S_WAIT_RP_ACT;
          end else begin
            cmd = C_ACT; tmr_d = TMR_W'(T_RCD - 1); state_d = S_WAIT_RCD;
          end
        end
      end
      S_WAIT_RCD: if (tmr == '0) begin
        cmd = C_RW;
        if (ap_eff) begin tmr_d = TMR_W'(T_RP - 1); state_d = S_WAIT_RP_IDLE; end
        else state_d = S_READY;
      end
      S_WAIT_RP_ACT: if (tmr == '0) begin
        cmd = C_ACT; tmr_d = TMR_W'(T_RCD - 1); state_d = S_WAIT_RCD;
      end
      S_WAIT_RP_REF: if (tmr == '0) begin
        cmd = C_REF; tmr_d = TMR_W'(T_RFC - 1); state_d = S_WAIT_RFC;
      end
      S_WAIT_RP_IDLE: if (tmr == '0) state_d = S_READY;
      S_WAIT_RFC: if (tmr == '0) begin
        ref_clear = 1'b1; state_d = S_READY;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Pin encoding of the chosen command; address/bank hold when the command does not use them.
  always_comb begin
    rw_addr              = '0;
    rw_addr[COL_W-1:0]   = cmd_col;
    rw_addr[10]          = ap_eff;
    rw_addr[12]          = cmd_bl8;
    prea_addr            = '0;
    prea_addr[10]        = 1'b1;
    cs_d = 1'b0; ras_d = 1'b1; cas_d = 1'b1; we_d = 1'b1;
    addr_d = Addr_out;
    ba_d   = BA_out;
    case (cmd)
      C_DESEL: cs_d = 1'b1;
      C_ACT:   begin ras_d = 1'b0; addr_d = cmd_row; ba_d = cmd_ba; end
      C_PRE:   begin ras_d = 1'b0; we_d = 1'b0; addr_d = '0; ba_d = cmd_ba; end
      C_PREA:  begin ras_d = 1'b0; we_d = 1'b0; addr_d = prea_addr; end
      C_RW:    begin cas_d = 1'b0; we_d = ~cmd_write; addr_d = rw_addr; ba_d = cmd_ba; end
      C_REF:   begin ras_d = 1'b0; cas_d = 1'b0; end
      default: ;
    endcase
  end

  // State, spacing timer and refresh interval tracking.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_INIT;
      tmr     <= '0;
      ref_cnt <= '0;
      ref_due <= 1'b0;
    end else begin
      state   <= state_d;
      tmr     <= tmr_d;
      ref_due <= ref_due_d;
      if (state == S_INIT || ref_wrap) ref_cnt <= '0;
      else                             ref_cnt <= ref_cnt + REF_W'(1);
    end
  end

  // Registered command/address pins and handshake outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      CS_n <= 1'b1; RAS_n <= 1'b1; CAS_n <= 1'b1; WE_n <= 1'b1;
      Addr_out  <= '0;
      BA_out    <= '0;
      CMD_RW    <= 1'b0;
      REQ_READY <= 1'b0;
    end else begin
      CS_n <= cs_d; RAS_n <= ras_d; CAS_n <= cas_d; WE_n <= we_d;
      Addr_out  <= addr_d;
      BA_out    <= ba_d;
      CMD_RW    <= (cmd == C_RW);
      REQ_READY <= (state_d == S_READY) && !ref_due_d;
    end
  end

  // Request latch and per-bank open-row bookkeeping.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bank_open <= '0;
      for (int i = 0; i < NUM_BANKS; i++) open_row[i] <= '0;
      lat_write <= 1'b0; lat_ap <= 1'b0; lat_bl8 <= 1'b0;
      lat_ba <= '0; lat_row <= '0; lat_col <= '0;
    end else begin
      if (accept) begin
        lat_write <= REQ_WRITE; lat_ap <= REQ_AP; lat_bl8 <= REQ_BL8;
        lat_ba <= REQ_BA; lat_row <= REQ_ROW; lat_col <= REQ_COL;
      end
      case (cmd)
        C_ACT:   begin bank_open[cmd_ba] <= 1'b1; open_row[cmd_ba] <= cmd_row; end
        C_PRE:   bank_open[cmd_ba] <= 1'b0;
        C_PREA:  bank_open <= '0;
        C_RW:    if (ap_eff) bank_open[cmd_ba] <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_bank_cmd_sequencer.sv
// tb/tb_ddr3_bank_cmd_sequencer.sv - scoreboard bench for ddr3_bank_cmd_sequencer
module tb_ddr3_bank_cmd_sequencer;

  logic        CLK, RESET_N, INIT_DONE, REQ_VALID, REQ_READY;
  logic        REQ_WRITE, REQ_AP, REQ_BL8;
  logic [2:0]  REQ_BA;
  logic [14:0] REQ_ROW;
  logic [9:0]  REQ_COL;
  logic        CS_n, RAS_n, CAS_n, WE_n, CMD_RW, REF_BUSY;
  logic [14:0] Addr_out;
  logic [2:0]  BA_out;
  logic [7:0]  BANK_OPEN;

  ddr3_bank_cmd_sequencer #(
    .NUM_BANKS(8), .BA_W(3), .ROW_W(15), .COL_W(10),
    .T_RCD(3), .T_RP(3), .T_RFC(8), .T_REFI(100)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .INIT_DONE(INIT_DONE),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_AP(REQ_AP), .REQ_BL8(REQ_BL8), .REQ_BA(REQ_BA), .REQ_ROW(REQ_ROW),
    .REQ_COL(REQ_COL), .CS_n(CS_n), .RAS_n(RAS_n), .CAS_n(CAS_n), .WE_n(WE_n),
    .Addr_out(Addr_out), .BA_out(BA_out), .CMD_RW(CMD_RW),
    .BANK_OPEN(BANK_OPEN), .REF_BUSY(REF_BUSY)
  );

  // {CS_n, RAS_n, CAS_n, WE_n, CMD_RW}
  localparam logic [4:0] P_ACT = 5'b00110;
  localparam logic [4:0] P_PRE = 5'b00100;
  localparam logic [4:0] P_RD  = 5'b01011;
  localparam logic [4:0] P_WR  = 5'b01001;
  localparam logic [4:0] P_REF = 5'b00010;

  typedef struct {
    string       name;
    int          cyc;
    logic [4:0]  pins;
    logic [14:0] addr;
    logic [14:0] amask;
    logic [2:0]  ba;
    bit          chk_ba;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void push(input string nm, input int c, input logic [4:0] p,
                               input logic [14:0] a, input logic [14:0] m,
                               input logic [2:0] b, input bit cb);
    exp_t e;
    e.name = nm; e.cyc = c; e.pins = p; e.addr = a; e.amask = m; e.ba = b; e.chk_ba = cb;
    sbq.push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Monitor: every command on the pins is popped against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #1;
      if (RESET_N) begin
        if (!CS_n && !(RAS_n && CAS_n && WE_n)) begin
          n_vec++;
          if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_cmd: got pins %b addr %h ba %0d at cycle %0d, want no command",
                     {CS_n, RAS_n, CAS_n, WE_n, CMD_RW}, Addr_out, BA_out, cyc);
          end else begin
            e = sbq.pop_front();
            if (cyc != e.cyc || {CS_n, RAS_n, CAS_n, WE_n, CMD_RW} != e.pins ||
                (Addr_out & e.amask) != (e.addr & e.amask) || (e.chk_ba && BA_out != e.ba)) begin
              n_bad++;
              $display("FAIL %s: got cyc %0d pins %b addr %h ba %0d, want cyc %0d pins %b addr %h ba %0d",
                       e.name, cyc, {CS_n, RAS_n, CAS_n, WE_n, CMD_RW}, Addr_out, BA_out,
                       e.cyc, e.pins, e.addr, e.ba);
            end
          end
        end else if (CMD_RW) begin
          n_vec++; n_bad++;
          $display("FAIL stray_cmd_rw: got CMD_RW 1 at cycle %0d without column command, want 0", cyc);
        end
      end
    end
  end

  // Present a request at a negedge and hold it until accepted; acc = accepting edge index.
  task automatic issue(input logic w, input logic ap, input logic bl8, input logic [2:0] ba,
                       input logic [14:0] row, input logic [9:0] col, output int acc);
    int n;
    n = 0;
    REQ_VALID = 1'b1; REQ_WRITE = w; REQ_AP = ap; REQ_BL8 = bl8;
    REQ_BA = ba; REQ_ROW = row; REQ_COL = col;
    while (!REQ_READY && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (!REQ_READY) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout: got REQ_READY 0 for %0d cycles, want 1", n);
      acc = -1000;
    end else begin
      acc = cyc + 1;
    end
    @(negedge CLK);
    REQ_VALID = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, want $finish");
    $fatal(1);
  end

  initial begin
    int i0, a1, a2, a3, a4, a5, a6;
    RESET_N = 1'b0; INIT_DONE = 1'b0; REQ_VALID = 1'b0; REQ_WRITE = 1'b0;
    REQ_AP = 1'b0; REQ_BL8 = 1'b0; REQ_BA = '0; REQ_ROW = '0; REQ_COL = '0;
    repeat (3) @(negedge CLK);
    chk("rst_cs_n", CS_n, 1); chk("rst_ras_cas_we", {RAS_n, CAS_n, WE_n}, 3'b111);
    chk("rst_addr", Addr_out, 0); chk("rst_ba", BA_out, 0);
    chk("rst_req_ready", REQ_READY, 0); chk("rst_cmd_rw", CMD_RW, 0);
    chk("rst_bank_open", BANK_OPEN, 0); chk("rst_ref_busy", REF_BUSY, 0);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    chk("init_cs_n", CS_n, 1); chk("init_req_ready", REQ_READY, 0);

    // 1: closed bank write -> ACT then WRITE T_RCD later
    INIT_DONE = 1'b1;
    i0 = cyc + 1;
    issue(1'b1, 1'b0, 1'b1, 3'd2, 15'h0123, 10'h040, a1);
    push("t1_act", a1, P_ACT, 15'h0123, 15'h7fff, 3'd2, 1'b1);
    push("t1_write", a1 + 3, P_WR, 15'h1040, 15'h7fff, 3'd2, 1'b1);
    chk("t1_bank_open", BANK_OPEN, 8'h04);

    // 2: row hit read -> READ one cycle after acceptance, accepted one cycle after WRITE
    issue(1'b0, 1'b0, 1'b1, 3'd2, 15'h0123, 10'h008, a2);
    push("t2_read_hit", a2, P_RD, 15'h1008, 15'h7fff, 3'd2, 1'b1);
    chk("t2_accept_cycle", a2, a1 + 4);

    // 3: row miss -> PRE, ACT, READ each T_RP / T_RCD apart
    issue(1'b0, 1'b0, 1'b0, 3'd2, 15'h0456, 10'h3ff, a3);
    push("t3_pre", a3, P_PRE, 15'h0000, 15'h0400, 3'd2, 1'b1);
    push("t3_act", a3 + 3, P_ACT, 15'h0456, 15'h7fff, 3'd2, 1'b1);
    push("t3_read", a3 + 6, P_RD, 15'h03ff, 15'h7fff, 3'd2, 1'b1);
    chk("t3_accept_cycle", a3, a2 + 1);

    // 4: refresh interval wraps with bank 2 open and a request waiting
    while (cyc < i0 + 99) @(negedge CLK);
    chk("t4_ready_pre_wrap", REQ_READY, 1); chk("t4_busy_pre_wrap", REF_BUSY, 0);
    chk("t4_bank_open_pre", BANK_OPEN, 8'h04);
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_AP = 1'b1; REQ_BL8 = 1'b0;
    REQ_BA = 3'd2; REQ_ROW = 15'h0456; REQ_COL = 10'h010;
    chk("t4_ready_at_wrap", REQ_READY, 0); chk("t4_busy_at_wrap", REF_BUSY, 1);
    push("t4_prea", i0 + 101, P_PRE, 15'h0400, 15'h0400, 3'd0, 1'b0);
    push("t4_ref", i0 + 104, P_REF, 15'h0000, 15'h0000, 3'd0, 1'b0);
    while (cyc < i0 + 105) @(negedge CLK);
    chk("t4_bank_cleared", BANK_OPEN, 0); chk("t4_ready_in_ref", REQ_READY, 0);
    while (cyc < i0 + 111) @(negedge CLK);
    chk("t4_ready_last_rfc", REQ_READY, 0); chk("t4_busy_last_rfc", REF_BUSY, 1);

    // 5: the held write with auto-precharge
    issue(1'b1, 1'b1, 1'b0, 3'd2, 15'h0456, 10'h010, a4);
    push("t5_act", a4, P_ACT, 15'h0456, 15'h7fff, 3'd2, 1'b1);
    push("t5_write_ap", a4 + 3, P_WR, 15'h0410, 15'h7fff, 3'd2, 1'b1);
    chk("t4_accept_after_ref", a4, i0 + 113);
    chk("t4_busy_cleared", REF_BUSY, 0);
    repeat (4) @(negedge CLK);
    chk("t5_bank_cleared", BANK_OPEN, 0);
    issue(1'b0, 1'b0, 1'b0, 3'd2, 15'h0456, 10'h020, a5);
    push("t5_act_after_ap", a5, P_ACT, 15'h0456, 15'h7fff, 3'd2, 1'b1);
    push("t5_read", a5 + 3, P_RD, 15'h0020, 15'h7fff, 3'd2, 1'b1);
    chk("t5_ap_spacing_ok", (a5 - (a4 + 3)) >= 3, 1);

    // 6: reset asserted during WAIT_RCD
    issue(1'b0, 1'b0, 1'b1, 3'd5, 15'h7fff, 10'h001, a6);
    push("t6_act", a6, P_ACT, 15'h7fff, 15'h7fff, 3'd5, 1'b1);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    chk("t6_cs_n", CS_n, 1); chk("t6_ras_cas_we", {RAS_n, CAS_n, WE_n}, 3'b111);
    chk("t6_addr", Addr_out, 0); chk("t6_ba", BA_out, 0);
    chk("t6_req_ready", REQ_READY, 0); chk("t6_cmd_rw", CMD_RW, 0);
    chk("t6_bank_open", BANK_OPEN, 0); chk("t6_ref_busy", REF_BUSY, 0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (10) @(negedge CLK);
    chk("t6_bank_open_after", BANK_OPEN, 0);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr3_bank_cmd_sequencer.md
Name: ddr3_bank_cmd_sequencer

Overview:
Parametrised DDR3 command sequencer. Successor to the single-bank command FSM: it tracks an open row per bank, enforces tRCD/tRP/tRFC with counters, and generates periodic refresh internally. A valid/ready request port sits upstream and the DDR3 command/address pins sit downstream; data-path and DQS handling live elsewhere. Power-on/ZQ initialisation is handled by a separate block, which signals completion on INIT_DONE.

Parameters:
NUM_BANKS, 8, number of banks tracked (power of 2)
BA_W, 3, bank address width, log2(NUM_BANKS)
ROW_W, 15, row address width
COL_W, 10, column address width (at most 10)
T_RCD, 5, cycles from ACT to column command (at least 2)
T_RP, 5, cycles from PRE/PREA or auto-precharge to next command (at least 2)
T_RFC, 10, cycles from REF to next command (at least 2)
T_REFI, 780, refresh interval in cycles (greater than T_RP+T_RFC+T_RCD+T_RP+4)

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous, active-low reset
INIT_DONE  in  1  level; high once external init/ZQ has completed
REQ_VALID  in  1  request present
REQ_READY  out  1  sequencer accepts request this cycle
REQ_WRITE  in  1  1 = write, 0 = read
REQ_AP  in  1  auto-precharge request
REQ_BL8  in  1  1 = BL8, 0 = BC4 (driven on A12)
REQ_BA  in  BA_W  bank
REQ_ROW  in  ROW_W  row
REQ_COL  in  COL_W  column
CS_n, RAS_n, CAS_n, WE_n  out  1 each  DDR3 command pins
Addr_out  out  ROW_W  address pins
BA_out  out  BA_W  bank pins
CMD_RW  out  1  one-cycle pulse when a READ/WRITE command is driven
BANK_OPEN  out  NUM_BANKS  per-bank open flag
REF_BUSY  out  1  high from refresh-due until refresh completes

Behaviour:
- Reset (async assert, sync deassert effect): CS_n=1, RAS_n=CAS_n=WE_n=1, Addr_out=0, BA_out=0, REQ_READY=0, CMD_RW=0, BANK_OPEN=0, REF_BUSY=0. State=INIT. Latched request dropped; all counters cleared. Reset mid-operation behaves identically.
- INIT: deselect (CS_n=1). Refresh counter held at 0. Go to READY on the first cycle INIT_DONE=1.
- Non-command cycles outside INIT drive NOP: CS_n=0, RAS_n=CAS_n=WE_n=1. Addr_out and BA_out hold their last value.
- All outputs are registered. A command appears on the pins in the cycle after the state decision.
- READY:
  - REQ_READY = 1 when no refresh is due.
  - Handshake on REQ_VALID && REQ_READY; request fields are latched.
  - Hit (bank open, same row): RW next.
  - Miss (bank open, different row): PRE with A10=0, then WAIT_RP, ACT, WAIT_RCD, RW.
  - Closed bank: ACT, WAIT_RCD, RW.
- Command encodings:
  - ACT: RAS_n=0, Addr_out=row, bank flagged open, row stored.
  - PRE: RAS_n=0, WE_n=0, A10=0; bank cleared.
  - PREA: same as PRE with A10=1; all banks cleared.
  - RW: CAS_n=0, WE_n=~REQ_WRITE; Addr_out[COL_W-1:0]=col, A10=REQ_AP, A12=REQ_BL8, other bits 0; CMD_RW=1 for one cycle.
- After RW: with AP, bank cleared and WAIT_RP is entered; otherwise return to READY. A second request can therefore be accepted one cycle after RW.
- Wait states: a counter loads T_x-1 on command issue; the state exits when it reaches 0. Command spacing is exactly T_x cycles (ACT at cycle n gives RW at n+T_RCD).
- Refresh:
  - Interval counter runs in all non-INIT states and wraps at T_REFI-1. On wrap, ref_due and REF_BUSY are set.
  - ref_due is serviced only from READY. It has priority over a REQ_VALID in the same cycle, so that request is not accepted.
  - If any bank is open: PREA, then WAIT_RP.
  - Then REF (RAS_n=CAS_n=0, WE_n=1), WAIT_RFC, clear ref_due and REF_BUSY, return to READY.
  - A wrap while ref_due is already set is absorbed; there is no queueing.
- INIT_DONE falling outside INIT is ignored.

Optional Feature:
DDR_CLOSED_PAGE_EN
- Defined: every RW is issued with A10=1 regardless of REQ_AP, so banks never stay open after a column command. Refresh always skips PREA.
- Undefined: open-page policy as above; REQ_AP is honoured.

Test Plan:
(bench: T_RCD=3, T_RP=3, T_RFC=8, T_REFI=100)
1. Reset then INIT_DONE=1; request write BA=2, row 0x0123, col 0x040, BL8 -> ACT at cycle n with Addr_out=0x0123, BA_out=2; WRITE at n+3 with Addr_out=0x1040; BANK_OPEN=0x04.
2. Follow with read BA=2, row 0x0123, col 0x008 -> READ (WE_n=1) one cycle after acceptance, no ACT.
3. Read BA=2, row 0x0456 -> PRE with A10=0 at m, ACT 0x0456 at m+3, READ at m+6.
4. Let the interval wrap with bank 2 open while REQ_VALID=1 -> REQ_READY=0; PREA (A10=1), then REF 3 cycles later; REQ_READY=1 8 cycles after REF; BANK_OPEN=0.
5. Write with REQ_AP=1 -> A10=1 on WRITE, bank cleared; next ACT is no earlier than 3 cycles later.
6. Assert RESET_N=0 during WAIT_RCD -> all outputs return to reset values immediately; no RW is issued after release.
